riscv_core_sys_sequencer: RTL and testbench

Sequenced SYSTEM-instruction and trap controller for the RV64IMAC execute stage. Decodes ECALL, EBREAK, MRET, WFI, CSR* and illegal SYSTEM encodings, arbitrates pending machine interrupts against the instruction in EX, and runs a small state machine. The state machine stalls the pipeline, emits CSR trap/return write strobes and issues a single PC redirect. It supersedes the purely combinational CSR control decode.

---
 rtl/riscv_core_sys_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_riscv_core_sys_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_sys_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_core_sys_sequencer: SYSTEM-instruction / trap sequencer for EX.      |
// | Optional WFI wait state: RISCV_CORE_WFI_EN.   Revision: 1.0                |
// +----------------------------------------------------------------------------+
module riscv_core_sys_sequencer #(
  parameter int XLEN    = 64,
  parameter int NUM_IRQ = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sys_valid,
  input  logic [31:0]        i_sys_instr,
  input  logic [XLEN-1:0]    i_sys_pc,
  input  logic [XLEN-1:0]    i_sys_mtvec,
  input  logic [XLEN-1:0]    i_sys_mepc,
  input  logic               i_sys_mie,
  input  logic [NUM_IRQ-1:0] i_sys_irq,
  output logic               o_sys_stall,
  output logic               o_sys_csr_wen,
  output logic               o_sys_csr_ren,
  output logic               o_sys_trap_wen,
  output logic               o_sys_mret_wen,
  output logic [XLEN-1:0]    o_sys_mepc,
  output logic [XLEN-1:0]    o_sys_mcause,
  output logic [XLEN-1:0]    o_sys_mtval,
  output logic               o_sys_redirect,
  output logic [XLEN-1:0]    o_sys_redirect_pc
);

  localparam logic [6:0]  C_OPC_SYSTEM = 7'b1110011;
  localparam logic [31:0] C_ECALL      = 32'h0000_0073;
  localparam logic [31:0] C_EBREAK     = 32'h0010_0073;
  localparam logic [31:0] C_MRET       = 32'h3020_0073;
  localparam logic [31:0] C_WFI        = 32'h1050_0073;

`ifdef RISCV_CORE_WFI_EN
  typedef enum logic [1:0] {IDLE = 2'd0, TRAP = 2'd1, REDIR = 2'd2, WAIT = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, TRAP = 2'd1, REDIR = 2'd2} state_e;
`endif

  state_e          state_q, state_d;
  logic [XLEN-1:0] mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            mret_q, mret_d;
`ifdef RISCV_CORE_WFI_EN
  logic [XLEN-1:0] wfi_pc_q, wfi_pc_d;
`endif

  logic [2:0]      funct3;
  logic            is_sys, is_ecall, is_ebreak, is_mret, is_wfi, is_illegal, is_csr;
  logic            accept, irq_any, irq_take, exc_acc, mret_acc, wfi_acc, csr_acc;
  logic [4:0]      irq_idx;
  logic [XLEN-1:0] irq_cause, mtvec_base, exc_cause;
  logic [1:0]      unused_mtvec;

  assign unused_mtvec = i_sys_mtvec[1:0];
  assign mtvec_base   = {i_sys_mtvec[XLEN-1:2], 2'b00};

  // Lowest-numbered pending line wins, so scan from the top down.
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_sys_irq[i]) irq_idx = 5'(i);
    end
  end

  assign irq_any   = |i_sys_irq;
  assign irq_cause = {1'b1, {(XLEN-6){1'b0}}, irq_idx};

  assign funct3     = i_sys_instr[14:12];
  assign is_sys     = (i_sys_instr[6:0] == C_OPC_SYSTEM);
  assign is_ecall   = (i_sys_instr == C_ECALL);
  assign is_ebreak  = (i_sys_instr == C_EBREAK);
  assign is_mret    = (i_sys_instr == C_MRET);
  assign is_wfi     = (i_sys_instr == C_WFI);
  assign is_illegal = is_sys && ((funct3 == 3'b100) ||
                      ((funct3 == 3'b000) && !(is_ecall || is_ebreak || is_mret || is_wfi)));
  assign is_csr     = is_sys && (funct3[1:0] != 2'b00);
  assign exc_cause  = is_ecall ? XLEN'(11) : (is_ebreak ? XLEN'(3) : XLEN'(2));

  assign accept   = i_sys_valid && (state_q == IDLE);
  assign irq_take = accept && i_sys_mie && irq_any;
  assign exc_acc  = accept && !irq_take && (is_ecall || is_ebreak || is_illegal);
  assign mret_acc = accept && !irq_take && is_mret;
  assign csr_acc  = accept && !irq_take && is_csr;
`ifdef RISCV_CORE_WFI_EN
  assign wfi_acc  = accept && !irq_take && is_wfi;
`else
  assign wfi_acc  = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    redir_pc_d = redir_pc_q;
    mret_d     = mret_q;
`ifdef RISCV_CORE_WFI_EN
    wfi_pc_d   = wfi_pc_q;
`endif
    case (state_q)
      IDLE: begin
        if (irq_take) begin
          state_d    = TRAP;
          mepc_d     = i_sys_pc;
          mcause_d   = irq_cause;
          mtval_d    = '0;
          redir_pc_d = mtvec_base;
          mret_d     = 1'b0;
        end else if (exc_acc) begin
          state_d    = TRAP;
          mepc_d     = i_sys_pc;
          mcause_d   = exc_cause;
          mtval_d    = is_illegal ? XLEN'(i_sys_instr) : '0;
          redir_pc_d = mtvec_base;
          mret_d     = 1'b0;
        end else if (mret_acc) begin
          state_d    = REDIR;
          redir_pc_d = i_sys_mepc;
          mret_d     = 1'b1;
        end
`ifdef RISCV_CORE_WFI_EN
        else if (wfi_acc) begin
          state_d  = WAIT;
          wfi_pc_d = i_sys_pc;
        end
`endif
      end
      TRAP:  state_d = REDIR;
      REDIR: begin
        state_d = IDLE;
        mret_d  = 1'b0;
      end
`ifdef RISCV_CORE_WFI_EN
      WAIT: begin
        if (irq_any && i_sys_mie) begin
          state_d    = TRAP;
          mepc_d     = wfi_pc_q + XLEN'(4);
          mcause_d   = irq_cause;
          mtval_d    = '0;
          redir_pc_d = mtvec_base;
          mret_d     = 1'b0;
        end else if (irq_any) begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      redir_pc_q <= '0;
      mret_q     <= 1'b0;
`ifdef RISCV_CORE_WFI_EN
      wfi_pc_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      redir_pc_q <= redir_pc_d;
      mret_q     <= mret_d;
`ifdef RISCV_CORE_WFI_EN
      wfi_pc_q   <= wfi_pc_d;
`endif
    end
  end

  // REDIR is deliberately excluded so fetch restarts on the redirect cycle.
  assign o_sys_stall = !i_rst && (irq_take || exc_acc || mret_acc || wfi_acc ||
                                  ((state_q != IDLE) && (state_q != REDIR)));
  assign o_sys_csr_wen  = !i_rst && csr_acc &&
                          ((funct3[1:0] == 2'b01) || (i_sys_instr[19:15] != 5'd0));
  assign o_sys_csr_ren  = !i_rst && csr_acc &&
                          ((funct3[1:0] != 2'b01) || (i_sys_instr[11:7] != 5'd0));
  assign o_sys_trap_wen = !i_rst && (state_q == TRAP);
  assign o_sys_mret_wen = !i_rst && (state_q == REDIR) && mret_q;
  assign o_sys_redirect = !i_rst && (state_q == REDIR);

  assign o_sys_mepc        = mepc_q;
  assign o_sys_mcause      = mcause_q;
  assign o_sys_mtval       = mtval_q;
  assign o_sys_redirect_pc = redir_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_sys_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_riscv_core_sys_sequencer: directed bench for riscv_core_sys_sequencer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_riscv_core_sys_sequencer;

  localparam int XLEN    = 64;
  localparam int NUM_IRQ = 16;
`ifdef RISCV_CORE_WFI_EN
  localparam logic WFI_ON = 1'b1;
`else
  localparam logic WFI_ON = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               valid;
  logic [31:0]        instr;
  logic [XLEN-1:0]    pc, mtvec, mepc_in;
  logic               mie;
  logic [NUM_IRQ-1:0] irq;
  logic               stall, csr_wen, csr_ren, trap_wen, mret_wen, redirect;
  logic [XLEN-1:0]    mepc, mcause, mtval, redirect_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  riscv_core_sys_sequencer #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ)) dut (
    .i_clk(clk), .i_rst(rst), .i_sys_valid(valid), .i_sys_instr(instr),
    .i_sys_pc(pc), .i_sys_mtvec(mtvec), .i_sys_mepc(mepc_in), .i_sys_mie(mie),
    .i_sys_irq(irq), .o_sys_stall(stall), .o_sys_csr_wen(csr_wen),
    .o_sys_csr_ren(csr_ren), .o_sys_trap_wen(trap_wen), .o_sys_mret_wen(mret_wen),
    .o_sys_mepc(mepc), .o_sys_mcause(mcause), .o_sys_mtval(mtval),
    .o_sys_redirect(redirect), .o_sys_redirect_pc(redirect_pc)
  );

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] instr;
    logic        mie;
    logic [15:0] irq;
    logic        stall;
    logic        wen;
    logic        ren;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid = 1'b0;
    rst   = 1'b1;
    cyc();
    rst   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; instr = 32'h0000_0013; pc = '0;
    mtvec = 64'h8000_0003; mepc_in = '0; mie = 1'b0; irq = '0;

    vt[0]  = '{"csrrs_rd5_rs0",   1'b1, 32'h3000_22F3, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{"csrrw_rd0_rs1",   1'b1, 32'h3050_9073, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vt[2]  = '{"csrrw_rd1_rs0",   1'b1, 32'h3000_10F3, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1};
    vt[3]  = '{"csrrci_rd0_u0",   1'b1, 32'h3000_7073, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
    vt[4]  = '{"csrrwi_rd0_u5",   1'b1, 32'h3052_D073, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
    vt[5]  = '{"addi_nop",        1'b1, 32'h0010_0093, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{"invalid_ecall",   1'b0, 32'h0000_0073, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{"ecall",           1'b1, 32'h0000_0073, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vt[8]  = '{"csr_irq_taken",   1'b1, 32'h3050_9073, 1'b1, 16'h0001, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{"csr_irq_masked",  1'b1, 32'h3050_9073, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0};
    vt[10] = '{"wfi",             1'b1, 32'h1050_0073, 1'b0, 16'h0000, WFI_ON, 1'b0, 1'b0};
    vt[11] = '{"illegal_f3_100",  1'b1, 32'h0000_4073, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vt[12] = '{"mret",            1'b1, 32'h3020_0073, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vt[13] = '{"ebreak",          1'b1, 32'h0010_0073, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0};

    cyc(); cyc();
    rst = 1'b0;
    #2;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_trap_wen", 64'(trap_wen), 64'd0);
    chk("rst_redirect", 64'(redirect), 64'd0);
    chk("rst_mepc", mepc, 64'd0);
    chk("rst_mcause", mcause, 64'd0);
    chk("rst_mtval", mtval, 64'd0);
    chk("rst_redirect_pc", redirect_pc, 64'd0);

    for (int k = 0; k < 14; k++) begin
      cyc();
      valid = vt[k].valid; instr = vt[k].instr; mie = vt[k].mie; irq = vt[k].irq;
      #2;
      chk({vt[k].name, "_stall"}, 64'(stall), 64'(vt[k].stall));
      chk({vt[k].name, "_wen"}, 64'(csr_wen), 64'(vt[k].wen));
      chk({vt[k].name, "_ren"}, 64'(csr_ren), 64'(vt[k].ren));
      cyc();
      mie = 1'b0; irq = '0;
      do_reset();
    end

    // ECALL: trap write one cycle later, redirect the cycle after.
    cyc();
    valid = 1'b1; instr = 32'h0000_0073; pc = 64'h8000_0100; mtvec = 64'h8000_0003;
    #2;
    chk("ecall_n_stall", 64'(stall), 64'd1);
    chk("ecall_n_trap_wen", 64'(trap_wen), 64'd0);
    cyc(); valid = 1'b0; #2;
    chk("ecall_n1_trap_wen", 64'(trap_wen), 64'd1);
    chk("ecall_n1_stall", 64'(stall), 64'd1);
    chk("ecall_n1_redirect", 64'(redirect), 64'd0);
    chk("ecall_mepc", mepc, 64'h8000_0100);
    chk("ecall_mcause", mcause, 64'd11);
    chk("ecall_mtval", mtval, 64'd0);
    cyc(); #2;
    chk("ecall_n2_redirect", 64'(redirect), 64'd1);
    chk("ecall_n2_redirect_pc", redirect_pc, 64'h8000_0000);
    chk("ecall_n2_stall", 64'(stall), 64'd0);
    chk("ecall_n2_trap_wen", 64'(trap_wen), 64'd0);
    cyc(); #2;
    chk("ecall_n3_redirect", 64'(redirect), 64'd0);

    // Interrupt pre-empts the ECALL; lowest set line (4) wins.
    valid = 1'b1; instr = 32'h0000_0073; pc = 64'h8000_0120; mie = 1'b1; irq = 16'h0090;
    #1;
    chk("irq_n_stall", 64'(stall), 64'd1);
    chk("irq_n_csr", 64'({csr_wen, csr_ren}), 64'd0);
    cyc(); valid = 1'b0; irq = '0; mie = 1'b0; #2;
    chk("irq_trap_wen", 64'(trap_wen), 64'd1);
    chk("irq_mcause", mcause, 64'h8000_0000_0000_0004);
    chk("irq_mepc", mepc, 64'h8000_0120);
    cyc(); #2;
    chk("irq_redirect_pc", redirect_pc, 64'h8000_0000);

    // MRET: target is the mepc input at accept; trap data stays put.
    cyc();
    valid = 1'b1; instr = 32'h3020_0073; mepc_in = 64'h8000_0200;
    #2;
    chk("mret_n_stall", 64'(stall), 64'd1);
    cyc(); valid = 1'b0; mepc_in = '0; #2;
    chk("mret_n1_mret_wen", 64'(mret_wen), 64'd1);
    chk("mret_n1_redirect", 64'(redirect), 64'd1);
    chk("mret_n1_redirect_pc", redirect_pc, 64'h8000_0200);
    chk("mret_n1_trap_wen", 64'(trap_wen), 64'd0);
    chk("mret_n1_stall", 64'(stall), 64'd0);
    chk("mret_mepc_hold", mepc, 64'h8000_0120);
    cyc(); #2;
    chk("mret_n2_stall", 64'(stall), 64'd0);
    chk("mret_n2_mret_wen", 64'(mret_wen), 64'd0);
    chk("mret_n2_redirect", 64'(redirect), 64'd0);

    // Illegal SYSTEM encoding reports the instruction in mtval.
    cyc();
    valid = 1'b1; instr = 32'h0000_4073; pc = 64'h8000_0300;
    cyc(); valid = 1'b0; #2;
    chk("ill_trap_wen", 64'(trap_wen), 64'd1);
    chk("ill_mcause", mcause, 64'd2);
    chk("ill_mtval", mtval, 64'h0000_4073);
    cyc(); cyc();

    // Reset while in TRAP: no redirect or trap write afterwards.
    valid = 1'b1; instr = 32'h0010_0073; pc = 64'h8000_0310;
    cyc(); valid = 1'b0; rst = 1'b1; #2;
    chk("rstt_trap_wen_gated", 64'(trap_wen), 64'd0);
    cyc(); rst = 1'b0; #2;
    chk("rstt_redirect_a", 64'(redirect), 64'd0);
    chk("rstt_trap_wen_a", 64'(trap_wen), 64'd0);
    chk("rstt_stall_a", 64'(stall), 64'd0);
    chk("rstt_mcause_cleared", mcause, 64'd0);
    cyc(); #2;
    chk("rstt_redirect_b", 64'(redirect), 64'd0);

`ifdef RISCV_CORE_WFI_EN
    cyc();
    valid = 1'b1; instr = 32'h1050_0073; pc = 64'h8000_0400; mie = 1'b1; irq = '0;
    #2;
    chk("wfi_accept_stall", 64'(stall), 64'd1);
    cyc(); valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("wfi_wait_stall", 64'(stall), 64'd1);
      chk("wfi_wait_trap_wen", 64'(trap_wen), 64'd0);
      cyc();
    end
    irq = 16'h0008; #2;
    chk("wfi_wake_stall", 64'(stall), 64'd1);
    cyc(); irq = '0; #2;
    chk("wfi_trap_wen", 64'(trap_wen), 64'd1);
    chk("wfi_mepc", mepc, 64'h8000_0404);
    chk("wfi_mcause", mcause, 64'h8000_0000_0000_0003);
    cyc(); #2;
    chk("wfi_redirect", 64'(redirect), 64'd1);
    cyc();
    valid = 1'b1; instr = 32'h1050_0073; pc = 64'h8000_0500; mie = 1'b0;
    cyc(); valid = 1'b0;
    cyc(); irq = 16'h0008; #2;
    chk("wfi0_wake_stall", 64'(stall), 64'd1);
    cyc(); irq = '0; #2;
    chk("wfi0_stall_drop", 64'(stall), 64'd0);
    chk("wfi0_no_trap", 64'(trap_wen), 64'd0);
    chk("wfi0_mepc_hold", mepc, 64'h8000_0404);
`else
    cyc();
    valid = 1'b1; instr = 32'h1050_0073; pc = 64'h8000_0400; mie = 1'b1; irq = '0;
    #2;
    chk("wfi_nop_stall", 64'(stall), 64'd0);
    cyc(); valid = 1'b0; #2;
    chk("wfi_nop_trap_wen", 64'(trap_wen), 64'd0);
    chk("wfi_nop_redirect", 64'(redirect), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
